// File: rtl/mux_41_rr_sel_pkg.sv
// Shared types and constants for the 4-channel round-robin mux select arbiter.
package mux_41_rr_sel_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_41_rr_sel_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface mux_41_rr_sel_if;
    import mux_41_rr_sel_pkg::*;

    logic [NUM_CH-1:0] req_i;
    logic              release_i;
    logic [SEL_W-1:0]  sel_o;
    logic [NUM_CH-1:0] gnt_o;
    logic              valid_o;
    logic              timeout_o;

    modport master (
        output req_i, release_i,
        input  sel_o, gnt_o, valid_o, timeout_o
    );

    modport slave (
        input  req_i, release_i,
        output sel_o, gnt_o, valid_o, timeout_o
    );

endinterface

// File: rtl/mux_41_rr_sel_pick.sv
// Combinational round-robin pick: first requester after ptr (ptr itself last),
// optionally masking out one channel (the current owner).
module rr_pick_41
    import mux_41_rr_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    input  logic              excl_en_i,
    input  logic [SEL_W-1:0]  excl_idx_i,
    output logic              any_o,
    output logic [SEL_W-1:0]  idx_o
);
    logic [NUM_CH-1:0] masked;
    logic [SEL_W-1:0]  cand;

    always_comb begin
        masked = req_i;
        if (excl_en_i) begin
            masked[excl_idx_i] = 1'b0;
        end
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        // Walk farthest offset first so the nearest candidate overwrites last.
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            cand = ptr_i + SEL_W'(k);
            if (masked[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/mux_41_rr_sel.sv
// Round-robin arbiter producing the 2-bit select for a 4:1 mux.
// Optional hold-limit forced release enabled by defining ARB_TIMEOUT_EN.
module mux_41_rr_sel
    import mux_41_rr_sel_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_41_rr_sel_if.slave arb
);
    arb_state_e        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              valid_q, valid_d;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic [SEL_W-1:0]  grant_idx;
    logic              excl_en;
    logic              owner_req;
    logic              end_grant;
    logic              load_grant;
    logic              forced;

    if ((32'd1 << CNT_W) <= HOLD_MAX) begin : g_cfg_err
        $error("CNT_W too narrow for HOLD_MAX");
    end

    assign excl_en   = (state_q == ST_GRANT);
    assign owner_req = arb.req_i[sel_q];

    rr_pick_41 u_pick (
        .req_i      (arb.req_i),
        .ptr_i      (ptr_q),
        .excl_en_i  (excl_en),
        .excl_idx_i (sel_q),
        .any_o      (pick_any),
        .idx_o      (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    assign forced = excl_en && !arb.release_i && owner_req
                    && (cnt_q == CNT_W'(HOLD_MAX - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_grant || (state_d == ST_IDLE)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(HOLD_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= forced;
        end
    end

    assign arb.timeout_o = timeout_q;
`else
    assign forced        = 1'b0;
    assign arb.timeout_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;
        end_grant  = 1'b0;
        load_grant = 1'b0;
        grant_idx  = pick_idx;
        case (state_q)
            ST_IDLE: begin
                load_grant = pick_any;
            end
            ST_GRANT: begin
                end_grant = arb.release_i || !owner_req || forced;
                if (end_grant) begin
                    if (pick_any) begin
                        load_grant = 1'b1;
                    end else if (owner_req) begin
                        // Sole requester still asking: hand the grant straight back.
                        load_grant = 1'b1;
                        grant_idx  = sel_q;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_grant) begin
            state_d = ST_GRANT;
            ptr_d   = grant_idx;
            sel_d   = grant_idx;
            gnt_d   = onehot(grant_idx);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '1;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign arb.sel_o   = sel_q;
    assign arb.gnt_o   = gnt_q;
    assign arb.valid_o = valid_q;

endmodule

// File: tb/tb_mux_41_rr_sel.sv
// Scoreboard bench for mux_41_rr_sel: directed vectors push expected outputs,
// a negedge monitor pops and compares them plus per-cycle invariants.
module tb_mux_41_rr_sel;
    import mux_41_rr_sel_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_41_rr_sel_if bus ();

    mux_41_rr_sel #(
        .HOLD_MAX (4),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic        chk_sel;
        logic        tmo;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  mux_i;
    logic        mux_o;

    assign mux_o = mux_i[bus.sel_o];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic rl,
                        input logic [3:0] eg, input logic [1:0] es, input logic cs,
                        input logic et, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.req_i     = rq;
        bus.release_i = rl;
        mux_i         = 4'($urandom);
        e.cyc     = cyc + 1;
        e.gnt     = eg;
        e.sel     = es;
        e.chk_sel = cs;
        e.tmo     = et;
        e.name    = nm;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            check("inv_onehot", 32'($countones(bus.gnt_o) <= 1), 32'd1);
            check("inv_valid", 32'(bus.valid_o), 32'(|bus.gnt_o));
            if (bus.valid_o === 1'b1) begin
                check("inv_gnt_sel", 32'(bus.gnt_o), 32'(onehot(bus.sel_o)));
                check("inv_mux_o", 32'(mux_o), 32'(|(mux_i & bus.gnt_o)));
            end
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            check({e.name, "_gnt"}, 32'(bus.gnt_o), 32'(e.gnt));
            check({e.name, "_valid"}, 32'(bus.valid_o), 32'(|e.gnt));
            check({e.name, "_timeout"}, 32'(bus.timeout_o), 32'(e.tmo));
            if (e.chk_sel) begin
                check({e.name, "_sel"}, 32'(bus.sel_o), 32'(e.sel));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.req_i     = 4'b0000;
        bus.release_i = 1'b0;
        mux_i         = 4'b0000;

        // 1: reset, single request, then idle
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t1_rst0");
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t1_rst1");
        step(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "t1_grant0");
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t1_drop");
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t1_idle");

        // 2: all request with release every cycle, full rotation, no gap
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t2_rst");
        step(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0, "t2_rr0");
        step(0, 4'b1111, 1, 4'b0010, 2'd1, 1, 0, "t2_rr1");
        step(0, 4'b1111, 1, 4'b0100, 2'd2, 1, 0, "t2_rr2");
        step(0, 4'b1111, 1, 4'b1000, 2'd3, 1, 0, "t2_rr3");
        step(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0, "t2_rr4");
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t2_idle");

        // 3: skip non-requesting channel, no pre-emption by non-owners
        step(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0, "t3_grant1");
        step(0, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "t3_no_preempt");
        step(0, 4'b1010, 1, 4'b1000, 2'd3, 1, 0, "t3_next3");
        step(0, 4'b1010, 1, 4'b0010, 2'd1, 1, 0, "t3_back1");
        step(0, 4'b0000, 0, 4'b0000, 2'd1, 1, 0, "t3_idle_hold_sel");

        // 4: owner drops to idle, release in idle ignored, sole-requester re-grant
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "t4_grant2");
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "t4_hold");
        step(0, 4'b0000, 0, 4'b0000, 2'd2, 1, 0, "t4_drop");
        step(0, 4'b0000, 1, 4'b0000, 2'd2, 1, 0, "t4_rel_idle");
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "t4_grant2b");
        step(0, 4'b0100, 1, 4'b0100, 2'd2, 1, 0, "t4_regrant");
        step(0, 4'b0000, 0, 4'b0000, 2'd2, 1, 0, "t4_idle");

        // 5: hold limit behaviour
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t5_rst");
        step(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "t5_grant0");
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "t5_hold");
        end
        step(0, 4'b0011, 0, 4'b0010, 2'd1, 1, 1, "t5_timeout");
        step(0, 4'b0011, 0, 4'b0010, 2'd1, 1, 0, "t5_after");
        step(0, 4'b0000, 0, 4'b0000, 2'd1, 1, 0, "t5_idle");
`else
        for (int i = 0; i < 22; i++) begin
            step(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0, "t5_hold");
        end
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t5_idle");
`endif

        // 6: reset mid-grant restores pointer so ch0 wins next
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t6_rst");
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "t6_grant3");
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "t6_hold3");
        step(1, 4'b1000, 0, 4'b0000, 2'd0, 1, 0, "t6_rst_mid");
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "t6_first0");
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "t6_hold0");
        step(0, 4'b0000, 0, 4'b0000, 2'd0, 1, 0, "t6_idle");

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
